priority_encoder_rr: RTL and testbench

Parametrised N-to-log2(N) priority encoder with a registered output stage, valid/ready handshakes on both sides, and a selectable round-robin mode. It succeeds the team's fixed 8x3 encoders in request-steering and interrupt-collapse paths. Those paths need arbitrary widths, a defined result for multi-hot and all-zero inputs, fair rotation among simultaneous requests, and back-pressure.

---
 rtl/encoder_pkg.sv | 18 +
 rtl/prio_search.sv | 38 +++
 rtl/priority_encoder_rr.sv | 83 ++++++++
 tb/tb_priority_encoder_rr.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the priority_encoder_rr family.
// Mode encodings and the clog2 used to size the encoded index.
package encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Constant-evaluable ceiling log2; returns at least 1 so a 2-input encoder gets a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_search.sv
// Combinational descending search from ptr with wrap (ptr, ptr-1, .., 0, N-1, .., ptr+1).
// The vector is doubled so the wrap becomes a plain highest-set-bit search under a mask.
module prio_search
  import encoder_pkg::*;
#(
  parameter int  N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] a,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] g,
  output logic         found
);

  logic [2*N-1:0] dbl;
  int             hit_idx;

  assign dbl = {a, a};

  // Upper copy index N+i is a[i]; everything above ptr+N lies past the start point and is masked.
  always_comb begin
    hit_idx = 0;
    found   = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (dbl[i] && (i <= int'(ptr) + N)) begin
        hit_idx = i;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    g = '0;
    if (hit_idx >= N) g = W'(hit_idx - N);
    else              g = W'(hit_idx);
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// N-to-clog2(N) priority encoder with a registered single-entry output stage
// and optional round-robin rotation of the search start pointer.
module priority_encoder_rr
  import encoder_pkg::*;
#(
  parameter int  N    = 8,
  parameter int  MODE = MODE_FIXED,
  localparam int W    = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         any
);

  localparam logic [W-1:0] PTR_TOP = W'(N - 1);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] y_q, y_d;
  logic         any_q, any_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         consume;
  logic [W-1:0] g;
  logic         found;

  prio_search #(.N(N)) u_search (
    .a     (a),
    .ptr   (ptr_q),
    .g     (g),
    .found (found)
  );

  // Handshake: a transfer happens on a side when valid && ready at the rising edge.
  // in_ready depends only on rst, the output register state and out_ready, so the
  // stage accepts a new vector in the same cycle its current result is consumed.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    any_d       = any_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = found ? g : '0;
      any_d       = found;
      // The winner drops to lowest priority; an all-zero vector leaves rotation alone.
      if ((MODE == MODE_RR) && found) begin
        ptr_d = (g == '0) ? PTR_TOP : g - 1'b1;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      any_q       <= 1'b0;
      ptr_q       <= PTR_TOP;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      any_q       <= any_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign any       = any_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: three instances (fixed N=8, round-robin N=8, round-robin N=5)
// share one stimulus stream; directed vectors plus a randomized scoreboard run.
module tb_priority_encoder_rr;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;

  logic       in_ready0, in_ready1, in_ready2;
  logic       out_valid0, out_valid1, out_valid2;
  logic [2:0] y0, y1, y2;
  logic       any0, any1, any2;

  int checks;
  int errors;

  logic [3:0] exp_q[$];

  priority_encoder_rr #(.N(8), .MODE(0)) dut_fix8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a),
    .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .any(any0)
  );

  priority_encoder_rr #(.N(8), .MODE(1)) dut_rr8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a),
    .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .any(any1)
  );

  priority_encoder_rr #(.N(5), .MODE(1)) dut_rr5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a[4:0]),
    .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .any(any2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference search: walk down from p with wrap over n indices.
  function automatic int model_search(input logic [7:0] av, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (p - k + n) % n;
      if (av[idx]) return idx;
    end
    return -1;
  endfunction

  int         m_n    [3];
  int         m_mode [3];
  int         m_ptr  [3];
  logic       m_valid[3];
  logic [2:0] m_y    [3];
  logic       m_any  [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ptr[i]   = m_n[i] - 1;
      m_valid[i] = 1'b0;
      m_y[i]     = '0;
      m_any[i]   = 1'b0;
    end
    exp_q.delete();
  endtask

  initial begin
    logic [2:0] ys[3];
    logic       vs[3];
    logic       as[3];
    logic       rs[3];
    checks = 0;
    errors = 0;
    m_n    = '{8, 8, 5};
    m_mode = '{0, 1, 1};

    // reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
    tick();
    check("rst_out_valid", 32'(out_valid0), 0);
    check("rst_y", 32'(y0), 0);
    check("rst_any", 32'(any0), 0);
    check("rst_in_ready", 32'(in_ready0), 0);
    check("rst_ptr_rr8", 32'(dut_rr8.ptr_q), 7);
    rst = 1'b0;

    // fixed priority vectors, first accept on first edge with rst low
    in_valid = 1'b1; a = 8'h02; tick();
    check("fix_v02_valid", 32'(out_valid0), 1);
    check("fix_v02_y", 32'(y0), 1);
    check("fix_v02_any", 32'(any0), 1);
    a = 8'h06; tick();
    check("fix_v06_y", 32'(y0), 2);
    check("fix_v06_any", 32'(any0), 1);
    a = 8'h80; tick();
    check("fix_v80_y", 32'(y0), 7);
    check("fix_v80_any", 32'(any0), 1);
    a = 8'h00; tick();
    check("fix_v00_valid", 32'(out_valid0), 1);
    check("fix_v00_y", 32'(y0), 0);
    check("fix_v00_any", 32'(any0), 0);
    in_valid = 1'b0; tick();
    check("fix_drain_valid", 32'(out_valid0), 0);

    // round-robin: 0x91 on N=8 and its low bits 0x11 on N=5
    do_reset();
    in_valid = 1'b1; a = 8'h91;
    tick();
    check("rr8_y0", 32'(y1), 7); check("rr8_ptr0", 32'(dut_rr8.ptr_q), 6);
    check("rr5_y0", 32'(y2), 4); check("rr5_ptr0", 32'(dut_rr5.ptr_q), 3);
    tick();
    check("rr8_y1", 32'(y1), 4); check("rr8_ptr1", 32'(dut_rr8.ptr_q), 3);
    check("rr5_y1", 32'(y2), 0); check("rr5_ptr1", 32'(dut_rr5.ptr_q), 4);
    tick();
    check("rr8_y2", 32'(y1), 0); check("rr8_ptr2", 32'(dut_rr8.ptr_q), 7);
    check("rr5_y2", 32'(y2), 4); check("rr5_ptr2", 32'(dut_rr5.ptr_q), 3);
    tick();
    check("rr8_y3", 32'(y1), 7); check("rr8_ptr3", 32'(dut_rr8.ptr_q), 6);
    check("fix_91_y", 32'(y0), 7);

    // back-pressure
    do_reset();
    in_valid = 1'b1; a = 8'h02; tick();
    check("bp_first_y", 32'(y0), 1);
    out_ready = 1'b0; a = 8'h40; #1;
    check("bp_in_ready_low", 32'(in_ready0), 0);
    tick();
    check("bp_stall1_y", 32'(y0), 1);
    check("bp_stall1_valid", 32'(out_valid0), 1);
    a = 8'h20; tick();
    check("bp_stall2_y", 32'(y0), 1);
    check("bp_stall2_in_ready", 32'(in_ready0), 0);
    a = 8'h10; tick();
    check("bp_stall3_y", 32'(y0), 1);
    out_ready = 1'b1; a = 8'h08; #1;
    check("bp_release_in_ready", 32'(in_ready0), 1);
    tick();
    check("bp_nobubble_valid", 32'(out_valid0), 1);
    check("bp_nobubble_y", 32'(y0), 3);

    // reset mid-stream with rr8 ptr at 3
    do_reset();
    in_valid = 1'b1; a = 8'h91; tick(); tick();
    check("mid_ptr_before", 32'(dut_rr8.ptr_q), 3);
    check("mid_valid_before", 32'(out_valid1), 1);
    rst = 1'b1; tick();
    check("mid_rst_valid", 32'(out_valid1), 0);
    check("mid_rst_y", 32'(y1), 0);
    check("mid_rst_any", 32'(any1), 0);
    check("mid_rst_in_ready", 32'(in_ready1), 0);
    rst = 1'b0; tick();
    check("mid_after_y", 32'(y1), 7);
    check("mid_after_ptr", 32'(dut_rr8.ptr_q), 6);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      #1;
      rs = '{in_ready0, in_ready1, in_ready2};
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rnd_in_ready%0d", i), 32'(rs[i]), 32'(!m_valid[i] || out_ready));
      end
      if (out_valid1 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_sb_empty", 32'(exp_q.size()), 1);
        end else begin
          check("rnd_sb_result", 32'({any1, y1}), 32'(exp_q.pop_front()));
        end
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (in_valid && (!m_valid[i] || out_ready)) begin
          int gi;
          gi = model_search(a, m_ptr[i], m_n[i]);
          m_valid[i] = 1'b1;
          m_any[i]   = (gi >= 0);
          m_y[i]     = (gi >= 0) ? 3'(gi) : 3'd0;
          if (m_mode[i] == 1 && gi >= 0) m_ptr[i] = (gi == 0) ? m_n[i] - 1 : gi - 1;
          if (i == 1) exp_q.push_back({m_any[i], m_y[i]});
        end else if (m_valid[i] && out_ready) begin
          m_valid[i] = 1'b0;
        end
      end
      #1;
      vs = '{out_valid0, out_valid1, out_valid2};
      ys = '{y0, y1, y2};
      as = '{any0, any1, any2};
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rnd_valid%0d", i), 32'(vs[i]), 32'(m_valid[i]));
        if (m_valid[i]) begin
          check($sformatf("rnd_y%0d", i), 32'(ys[i]), 32'(m_y[i]));
          check($sformatf("rnd_any%0d", i), 32'(as[i]), 32'(m_any[i]));
        end
      end
      check("rnd_ptr_rr5", 32'(dut_rr5.ptr_q), 32'(m_ptr[2]));
    end
    check("rnd_sb_leftover", 32'(exp_q.size()), 32'(m_valid[1] ? 1 : 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
